// File: rtl/ur_ram_pkg.sv
// Shared defaults and types for the UR RAM arbiter and its round-robin picker.
package ur_ram_pkg;

  localparam int NUM_REQ_DEF  = 3;
  localparam int ADDR_W_DEF   = 11;
  localparam int DATA_W_DEF   = 128;
  localparam int LOCK_MAX_DEF = 16;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Index width that stays at least one bit for degenerate counts.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ur_ram_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to index 0.
module rr_pick
  import ur_ram_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] hi_req;
  logic         found;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign hi_mask[gi] = (gi >= int'(ptr));
    end
  endgenerate

  assign hi_req = req & hi_mask;
  assign any    = |req;

  // Requests at or above the pointer take priority; the low half is the wrap-around.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && hi_req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = IDX_W'(k);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/ur_ram_arb.sv
// Round-robin arbiter with burst lock in front of a single-port UR RAM;
// read data is registered so every requester sees one cycle of latency.
module ur_ram_arb
  import ur_ram_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  input  logic [DATA_W-1:0]         ram_rdata,
  output logic                      lock_timeout
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int CNT_W = idx_w(LOCK_MAX);

  arb_state_e         state_reg, state_next;
  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]   lock_owner_reg, lock_owner_next;
  logic [CNT_W-1:0]   idle_cnt_reg, idle_cnt_next;
  logic [NUM_REQ-1:0] rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0]  rsp_rdata_reg, rsp_rdata_next;
  logic               lock_timeout_reg, lock_timeout_next;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
  logic [NUM_REQ-1:0] owner_mask;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   winner;
  logic               accept;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] x);
    return (x == IDX_W'(NUM_REQ - 1)) ? '0 : x + 1'b1;
  endfunction

  // While locked only the owner is visible to the picker, so nobody else is ever granted.
  assign owner_mask = NUM_REQ'(1) << lock_owner_reg;
  assign eligible   = (state_reg == ST_LOCKED) ? (req_valid & owner_mask) : req_valid;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (eligible),
    .ptr   (rr_ptr_reg),
    .grant (grant),
    .idx   (winner),
    .any   (accept)
  );

  assign req_ready = grant;

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (accept) begin
      ram_we    = req_we[winner];
      ram_addr  = addr_arr[winner];
      ram_wdata = wdata_arr[winner];
    end
  end

  always_comb begin
    state_next        = state_reg;
    rr_ptr_next       = rr_ptr_reg;
    lock_owner_next   = lock_owner_reg;
    idle_cnt_next     = idle_cnt_reg;
    rsp_valid_next    = '0;
    rsp_rdata_next    = rsp_rdata_reg;
    lock_timeout_next = 1'b0;

    // The RAM read is asynchronous, so the word is captured at the edge ending the accept cycle.
    if (accept && !req_we[winner]) begin
      rsp_valid_next = grant;
      rsp_rdata_next = ram_rdata;
    end

    case (state_reg)
      ST_ARB: begin
        if (accept) begin
          rr_ptr_next = next_idx(winner);
          if (req_lock[winner]) begin
            state_next      = ST_LOCKED;
            lock_owner_next = winner;
            idle_cnt_next   = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (accept) begin
          idle_cnt_next = '0;
          if (!req_lock[winner]) begin
            state_next  = ST_ARB;
            rr_ptr_next = next_idx(lock_owner_reg);
          end
        end else if (idle_cnt_reg == CNT_W'(LOCK_MAX - 1)) begin
          state_next        = ST_ARB;
          rr_ptr_next       = next_idx(lock_owner_reg);
          idle_cnt_next     = '0;
          lock_timeout_next = 1'b1;
        end else begin
          idle_cnt_next = idle_cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_ARB;
      rr_ptr_reg       <= '0;
      lock_owner_reg   <= '0;
      idle_cnt_reg     <= '0;
      rsp_valid_reg    <= '0;
      rsp_rdata_reg    <= '0;
      lock_timeout_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      rr_ptr_reg       <= rr_ptr_next;
      lock_owner_reg   <= lock_owner_next;
      idle_cnt_reg     <= idle_cnt_next;
      rsp_valid_reg    <= rsp_valid_next;
      rsp_rdata_reg    <= rsp_rdata_next;
      lock_timeout_reg <= lock_timeout_next;
    end
  end

  assign rsp_valid    = rsp_valid_reg;
  assign rsp_rdata    = rsp_rdata_reg;
  assign lock_timeout = lock_timeout_reg;

endmodule
